// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM command port between the ROM-download byte packer and NPORT read requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin read grants; otherwise the lowest port index wins.
module sdram_port_arbiter #(
    parameter int AW    = 22,
    parameter int DW    = 16,
    parameter int NPORT = 4
) (
    input  logic                clk_96M,
    input  logic                reset_n,
    input  logic                rom_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [NPORT-1:0]    port_req,
    input  logic [NPORT*AW-1:0] port_addr,
    output logic [NPORT-1:0]    port_valid,
    output logic [DW-1:0]       port_dout,
    output logic                cmd_req,
    output logic                cmd_we,
    output logic [AW-1:0]       cmd_addr,
    output logic [DW-1:0]       cmd_wdata,
    output logic [1:0]          cmd_be,
    input  logic                cmd_ack,
    input  logic                rd_valid,
    input  logic [DW-1:0]       rd_data,
    output logic                dl_overflow
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t          state_q;
    logic            cmd_req_q, cmd_we_q;
    logic [AW-1:0]   cmd_addr_q;
    logic [DW-1:0]   cmd_wdata_q;
    logic [1:0]      cmd_be_q;
    logic [NPORT-1:0] port_valid_q;
    logic [DW-1:0]   port_dout_q;
    logic [IW-1:0]   grant_q;
    logic            dl_overflow_q;

    logic            rom_dl_q, pend_q;
    logic [7:0]      pend_lo_q;
    logic [AW-1:0]   pend_addr_q;
    logic [AW-1:0]   fifo_addr_q [2];
    logic [DW-1:0]   fifo_data_q [2];
    logic [1:0]      fifo_be_q   [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      cnt_q, cnt_d;

    logic            even_wr, odd_wr, dl_fall, push, pop, push_ok, rd_grant;
    logic [AW-1:0]   push_addr, sel_addr;
    logic [DW-1:0]   push_data;
    logic [1:0]      push_be;
    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^ioctl_addr[24:AW+1];

    assign even_wr   = rom_download & ioctl_wr & ~ioctl_addr[0];
    assign odd_wr    = rom_download & ioctl_wr &  ioctl_addr[0];
    assign dl_fall   = rom_dl_q & ~rom_download;
    assign push      = odd_wr | (dl_fall & pend_q);
    assign push_addr = odd_wr ? ioctl_addr[AW:1] : pend_addr_q;
    assign push_data = odd_wr ? DW'({ioctl_dout, pend_lo_q}) : DW'({8'h00, pend_lo_q});
    assign push_be   = odd_wr ? 2'b11 : 2'b01;
    // The head entry stays in the FIFO until the controller accepts it.
    assign pop       = (state_q == ISSUE) & cmd_we_q & cmd_ack;
    assign push_ok   = push & ((cnt_q != 2'd2) | pop);
    assign rd_grant  = (cnt_q == 2'd0) & ~rom_download & gnt_any & (port_valid_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)
            cnt_d = cnt_q + 2'd1;
        else if (!push_ok && pop)
            cnt_d = cnt_q - 2'd1;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_q;

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NPORT)
                j = j - NPORT;
            if (port_req[IW'(j)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk_96M or negedge reset_n) begin
        if (!reset_n)
            rr_ptr_q <= '0;
        else if (state_q == IDLE && rd_grant)
            rr_ptr_q <= (gnt_idx == IW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (port_req[IW'(k)]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NPORT; k++)
            if (gnt_idx == IW'(k))
                sel_addr = port_addr[k*AW +: AW];
    end

    always_ff @(posedge clk_96M or negedge reset_n) begin
        if (!reset_n) begin
            rom_dl_q      <= 1'b0;
            pend_q        <= 1'b0;
            pend_lo_q     <= '0;
            pend_addr_q   <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            dl_overflow_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
                fifo_be_q[i]   <= '0;
            end
        end else begin
            rom_dl_q <= rom_download;
            cnt_q    <= cnt_d;
            if (push_ok) begin
                fifo_addr_q[wr_ptr_q] <= push_addr;
                fifo_data_q[wr_ptr_q] <= push_data;
                fifo_be_q[wr_ptr_q]   <= push_be;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            if (push && !push_ok)
                dl_overflow_q <= 1'b1;
            if (even_wr) begin
                pend_q      <= 1'b1;
                pend_lo_q   <= ioctl_dout;
                pend_addr_q <= ioctl_addr[AW:1];
            end else if (push) begin
                pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_96M or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cmd_req_q    <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_be_q     <= '0;
            port_valid_q <= '0;
            port_dout_q  <= '0;
            grant_q      <= '0;
        end else begin
            port_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (cnt_q != 2'd0) begin
                        state_q     <= ISSUE;
                        cmd_req_q   <= 1'b1;
                        cmd_we_q    <= 1'b1;
                        cmd_addr_q  <= fifo_addr_q[rd_ptr_q];
                        cmd_wdata_q <= fifo_data_q[rd_ptr_q];
                        cmd_be_q    <= fifo_be_q[rd_ptr_q];
                    end else if (rd_grant) begin
                        state_q     <= ISSUE;
                        cmd_req_q   <= 1'b1;
                        cmd_we_q    <= 1'b0;
                        cmd_addr_q  <= sel_addr;
                        cmd_wdata_q <= '0;
                        cmd_be_q    <= 2'b11;
                        grant_q     <= gnt_idx;
                    end
                end
                ISSUE: begin
                    if (cmd_ack) begin
                        cmd_req_q <= 1'b0;
                        state_q   <= cmd_we_q ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (rd_valid) begin
                        port_dout_q  <= rd_data;
                        port_valid_q <= NPORT'(1) << grant_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_req     = cmd_req_q;
    assign cmd_we      = cmd_we_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_wdata   = cmd_wdata_q;
    assign cmd_be      = cmd_be_q;
    assign port_valid  = port_valid_q;
    assign port_dout   = port_dout_q;
    assign dl_overflow = dl_overflow_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: download packing, reads, contention, overflow, reset.
module tb_sdram_port_arbiter;
    localparam int AW    = 22;
    localparam int DW    = 16;
    localparam int NPORT = 4;

    logic                clk_96M = 1'b0;
    logic                reset_n = 1'b0;
    logic                rom_download = 1'b0;
    logic                ioctl_wr = 1'b0;
    logic [24:0]         ioctl_addr = '0;
    logic [7:0]          ioctl_dout = '0;
    logic [NPORT-1:0]    port_req = '0;
    logic [NPORT*AW-1:0] port_addr = '0;
    logic [NPORT-1:0]    port_valid;
    logic [DW-1:0]       port_dout;
    logic                cmd_req, cmd_we;
    logic [AW-1:0]       cmd_addr;
    logic [DW-1:0]       cmd_wdata;
    logic [1:0]          cmd_be;
    logic                cmd_ack = 1'b0;
    logic                rd_valid = 1'b0;
    logic [DW-1:0]       rd_data = '0;
    logic                dl_overflow;

    int vecs = 0;
    int errs = 0;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .NPORT(NPORT)) dut (
        .clk_96M(clk_96M), .reset_n(reset_n), .rom_download(rom_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .port_req(port_req), .port_addr(port_addr), .port_valid(port_valid),
        .port_dout(port_dout), .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .cmd_ack(cmd_ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .dl_overflow(dl_overflow)
    );

    always #5 clk_96M = ~clk_96M;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_96M);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_cmd(input string tag);
        int n;
        n = 0;
        while (cmd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(cmd_req), 32'd1);
    endtask

    task automatic ack_cmd(input string tag);
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        chk({tag, "_reqdrop"}, 32'(cmd_req), 32'd0);
    endtask

    task automatic expect_wr(input string tag, input logic [AW-1:0] a, input logic [15:0] d,
                             input logic [15:0] mask, input logic [1:0] be);
        wait_cmd(tag);
        chk({tag, "_we"},   32'(cmd_we), 32'd1);
        chk({tag, "_addr"}, 32'(cmd_addr), 32'(a));
        chk({tag, "_data"}, 32'(cmd_wdata & mask), 32'(d));
        chk({tag, "_be"},   32'(cmd_be), 32'(be));
        ack_cmd(tag);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] onehot;
        int exp_p;

        // Reset state
        step();
        step();
        chk("rst_cmd_req", 32'(cmd_req), 32'd0);
        chk("rst_cmd_we", 32'(cmd_we), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_port_valid", 32'(port_valid), 32'd0);
        chk("rst_overflow", 32'(dl_overflow), 32'd0);
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(cmd_req), 32'd0);

        // Even-length download
        rom_download = 1'b1;
        step();
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        send_byte(25'd2, 8'h33);
        send_byte(25'd3, 8'h44);
        expect_wr("dl_w0", 22'd0, 16'h2211, 16'hFFFF, 2'b11);
        expect_wr("dl_w1", 22'd1, 16'h4433, 16'hFFFF, 2'b11);
        chk("dl_no_ovf", 32'(dl_overflow), 32'd0);
        rom_download = 1'b0;
        step();
        step();
        chk("dl_end_idle", 32'(cmd_req), 32'd0);

        // Odd-length download
        rom_download = 1'b1;
        step();
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        expect_wr("odd_w0", 22'd0, 16'hBBAA, 16'hFFFF, 2'b11);
        rom_download = 1'b0;
        step();
        expect_wr("odd_tail", 22'd1, 16'h00CC, 16'h00FF, 2'b01);

        // Single read with delayed ack
        port_addr[2*AW +: AW] = 22'h1234;
        port_req = 4'b0100;
        step();
        chk("rd_req_next", 32'(cmd_req), 32'd1);
        chk("rd_addr", 32'(cmd_addr), 32'h1234);
        chk("rd_we", 32'(cmd_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_hold_req", 32'(cmd_req), 32'd1);
            chk("rd_hold_addr", 32'(cmd_addr), 32'h1234);
        end
        ack_cmd("rd");
        step();
        chk("rd_no_early_valid", 32'(port_valid), 32'd0);
        rd_data  = 16'hBEEF;
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        chk("rd_valid", 32'(port_valid), 32'b0100);
        chk("rd_dout", 32'(port_dout), 32'hBEEF);
        port_req = '0;
        step();
        chk("rd_valid_pulse", 32'(port_valid), 32'd0);

        // Contention with all ports requesting
        pulse_reset();
        for (int i = 0; i < NPORT; i++)
            port_addr[i*AW +: AW] = AW'(32'h100 + i);
        port_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_p = t % NPORT;
`else
            exp_p = 0;
`endif
            onehot = 32'd1 << exp_p;
            wait_cmd("cont");
            chk("cont_addr", 32'(cmd_addr), 32'h100 + 32'(exp_p));
            ack_cmd("cont");
            rd_data  = 16'(16'hC000 + t);
            rd_valid = 1'b1;
            step();
            rd_valid = 1'b0;
            chk("cont_valid", 32'(port_valid), onehot);
            chk("cont_dout", 32'(port_dout), 32'hC000 + 32'(t));
            step();
            chk("cont_no_regrant", 32'(cmd_req), 32'd0);
        end
        port_req = '0;

        // Overflow with ack held off
        pulse_reset();
        rom_download = 1'b1;
        step();
        for (int b = 0; b < 5; b++)
            send_byte(25'(b), 8'(b + 1));
        chk("ovf_before", 32'(dl_overflow), 32'd0);
        send_byte(25'd5, 8'h06);
        chk("ovf_after", 32'(dl_overflow), 32'd1);
        rom_download = 1'b0;
        step();
        expect_wr("ovf_w0", 22'd0, 16'h0201, 16'hFFFF, 2'b11);
        expect_wr("ovf_w1", 22'd1, 16'h0403, 16'hFFFF, 2'b11);
        step();
        step();
        chk("ovf_w2_dropped", 32'(cmd_req), 32'd0);
        chk("ovf_sticky", 32'(dl_overflow), 32'd1);

        // Reset while waiting for read data
        pulse_reset();
        chk("rst_clears_ovf", 32'(dl_overflow), 32'd0);
        port_addr[0 +: AW] = 22'h55;
        port_req = 4'b0001;
        wait_cmd("wrd");
        ack_cmd("wrd");
        port_req = '0;
        pulse_reset();
        chk("wrd_rst_req", 32'(cmd_req), 32'd0);
        chk("wrd_rst_valid", 32'(port_valid), 32'd0);
        rd_data  = 16'h1111;
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        chk("wrd_stray_rd", 32'(port_valid), 32'd0);
        step();
        chk("wrd_stray_rd2", 32'(port_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port between the ROM-download writer and NPORT game-side read requesters (68000 program, sound CPU, tile/sprite fetchers).
- Sits between the armedf core's fetch logic and the SDRAM controller, in the clk_96M domain.
- During rom_download it packs ioctl bytes into 16-bit words and writes them; otherwise it arbitrates reads with one transaction outstanding.

Parameters:
- AW, 22: SDRAM word-address width.
- DW, 16: SDRAM data width (fixed 16; byte packing assumes it).
- NPORT, 4: number of read requesters (2..8).

Ports:
- clk_96M  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rom_download  in  1  download active.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- port_req  in  NPORT  per-port read request (level).
- port_addr  in  NPORT*AW  per-port word address; port i at [i*AW +: AW].
- port_valid  out  NPORT  one-cycle pulse, read data ready for port i.
- port_dout  out  DW  shared read data, qualified by port_valid.
- cmd_req  out  1  command request to SDRAM controller.
- cmd_we  out  1  1 = write.
- cmd_addr  out  AW  word address.
- cmd_wdata  out  DW  write data.
- cmd_be  out  2  byte enables: [1] = high byte, [0] = low byte.
- cmd_ack  in  1  controller accepted command, one-cycle pulse.
- rd_valid  in  1  read data valid, one-cycle pulse.
- rd_data  in  DW  read data.
- dl_overflow  out  1  sticky: byte lost because the write buffer was full.

Behaviour:
- Reset values: all outputs 0; state IDLE; buffer empty; round-robin pointer = 0.
- Byte packing:
  - Even ioctl_addr → low byte [7:0], odd → high byte [15:8].
  - Word address = ioctl_addr[AW:1].
  - Odd byte pushes {addr, word, be=11} into a 2-entry FIFO.
  - Falling edge of rom_download with an even byte pending pushes it with be=01.
- FIFO full on push: byte dropped, dl_overflow set. dl_overflow clears only on reset_n.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If FIFO non-empty: load the write → ISSUE, cmd_we=1.
  - Else if rom_download=0 and any port_req: select grant, latch port_addr → ISSUE, cmd_we=0.
  - Read grants are never issued while rom_download=1.
- ISSUE: cmd_req=1 with cmd_* stable until cmd_ack. On ack, cmd_req drops the same edge. Write → IDLE; read → WAIT_RD.
- WAIT_RD: on rd_valid, port_dout <= rd_data and port_valid[grant] pulses for exactly one cycle; → IDLE.
- Latency: port_req high in IDLE → cmd_req high on the next cycle. rd_valid → port_valid one cycle later (registered).
- The granted port is not re-evaluated in the cycle port_valid pulses. Requester keeps port_req high until port_valid, then drops it or presents a new address. A re-request is granted no earlier than 2 cycles after its valid.
- port_req dropped mid-transaction: the transaction completes and port_valid still pulses.
- cmd_ack and rd_valid are ignored outside ISSUE and WAIT_RD respectively. Unexpected rd_valid in IDLE produces no port_valid.
- A push and a pop of the FIFO in the same cycle are both honoured; occupancy is unchanged.
- rom_download rising while in WAIT_RD: the read completes normally, then writes take over.
- reset_n low at any time: immediate return to reset values. The outstanding command is abandoned and the controller must be reset together with this block.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: read grant is round-robin. Search starts at the port after the last granted port, wrapping NPORT-1 → 0; the pointer updates on grant.
- Undefined: fixed priority, lowest port index wins. The pointer logic is absent.

Test Plan:
- Download: bytes 0x11@0, 0x22@1, 0x33@2, 0x44@3 → writes addr 0 data 0x2211 be 11, then addr 1 data 0x4433 be 11; dl_overflow=0.
- Odd-length download: 0xAA@0, 0xBB@1, 0xCC@2, then rom_download falls → final write addr 1 data 0x??CC be 01.
- Single read: port_req[2]=1, addr 0x1234 → cmd_req next cycle, cmd_addr 0x1234, cmd_we=0. Delay cmd_ack by 3 cycles; rd_valid returns 0xBEEF → port_valid=0100 one cycle later, port_dout=0xBEEF.
- Contention: port_req=1111 held continuously.
  - With ARB_ROUND_ROBIN_EN: grant order 0,1,2,3,0.
  - Without it: port 0 is served every transaction.
- Overflow: hold cmd_ack low; push 3 full words → dl_overflow=1 after the 6th byte; first 2 words still written once ack resumes.
- Reset in WAIT_RD: reset_n low for 1 cycle → cmd_req=0, port_valid=0; a later rd_valid produces no port_valid.
